// File: rtl/link_transmitter.sv
// Upstream end of a router-to-router link. Flits are accepted through valid/ready and written
// into the downstream buffer. Credits track free downstream slots, and the head/tail framing is checked.
module link_transmitter #(
    parameter int  BUFFER_SIZE = 8,
    parameter int  FLIT_SIZE   = 8,
    localparam int CNT_W       = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic                 valid_i,
    input  logic                 head_i,
    input  logic                 tail_i,
    output logic                 ready_o,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 write_o,
    input  logic                 credit_i,
    output logic [CNT_W-1:0]     credits_o,
    output logic                 packet_active_o,
    output logic [1:0]           error_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        PACKET = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t               state_reg;
    logic [CNT_W-1:0]     credits_reg;
    logic [CNT_W-1:0]     credits_next;
    logic [FLIT_SIZE-1:0] data_reg;
    logic                 write_reg;
    logic [1:0]           error_reg;
    logic                 accept;
    logic                 overflow;
    logic                 framing_err;

    // ready comes from the registered count only. A credit that returns this cycle can raise it next cycle at the earliest.
    assign ready_o = (credits_reg != '0);
    assign accept  = valid_i & ready_o;

    always_comb begin
        credits_next = credits_reg;
        overflow     = 1'b0;
        if (accept && !credit_i) begin
            credits_next = credits_reg - ONE;
        end else if (!accept && credit_i) begin
            if (credits_reg == FULL) begin
                overflow = 1'b1;
            end else begin
                credits_next = credits_reg + ONE;
            end
        end
    end

    always_comb begin
        framing_err = 1'b0;
        if (accept) begin
            if (state_reg == IDLE) begin
                framing_err = ~head_i;
            end else begin
                framing_err = head_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            credits_reg <= FULL;
            data_reg    <= '0;
            write_reg   <= 1'b0;
            error_reg   <= 2'b00;
        end else begin
            credits_reg <= credits_next;
            write_reg   <= accept;
            if (accept) begin
                data_reg <= data_i;
            end
            error_reg <= error_reg | {framing_err, overflow};
            // A misframed flit is still forwarded, but it leaves the state unchanged.
            if (accept && !framing_err) begin
                case (state_reg)
                    IDLE:    if (!tail_i) state_reg <= PACKET;
                    PACKET:  if (tail_i)  state_reg <= IDLE;
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign data_o          = data_reg;
    assign write_o         = write_reg;
    assign credits_o       = credits_reg;
    assign packet_active_o = (state_reg == PACKET);
    assign error_o         = error_reg;

endmodule

// File: doc/link_transmitter.md
# link_transmitter

Upstream end of a router-to-router link: accepts flits from the local output stage through a valid/ready handshake and drives them, one per cycle, into the downstream input circular buffer. It uses credit-based flow control, so it never writes into a full downstream buffer. It holds one credit per free downstream slot and regains one credit each time the downstream buffer pops a flit. It also checks packet framing (head/tail) and flags protocol and credit errors.

## Interface
- BUFFER_SIZE, 8: depth of the downstream input buffer; initial credit count.
- FLIT_SIZE, 8: flit width in bits.
- CNT_W, clogb2(BUFFER_SIZE+1): credit counter width (derived localparam, not overridable).
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_i  input  FLIT_SIZE  flit from local output stage.
- valid_i  input  1  data_i/head_i/tail_i valid.
- head_i  input  1  flit is first of packet.
- tail_i  input  1  flit is last of packet (head_i&tail_i = single-flit packet).
- ready_o  output  1  transmitter can accept a flit this cycle.
- data_o  output  FLIT_SIZE  flit to downstream buffer data input.
- write_o  output  1  downstream buffer write strobe.
- credit_i  input  1  one-cycle pulse per flit popped by downstream buffer.
- credits_o  output  CNT_W  current credit count (free downstream slots).
- packet_active_o  output  1  FSM in PACKET state.
- error_o  output  2  sticky; bit0 = credit overflow, bit1 = framing error.

## Operation
- accept = valid_i & ready_o; ready_o = (credits_o != 0), derived from registered count only; a credit_i in the same cycle does not raise ready_o.
- Credit counter: next = count − accept + credit_i. accept & credit_i together → unchanged.
- Overflow: credit_i with count == BUFFER_SIZE and no accept → count stays BUFFER_SIZE, error_o[0] set.
- Underflow impossible by construction (accept requires count ≥ 1).
- On accept: data_o ← data_i, write_o ← 1 at next edge. No accept: write_o ← 0, data_o holds its last value.
- Framing FSM, states IDLE and PACKET, evaluated only on accept:
  - IDLE, head_i&tail_i → IDLE.
  - IDLE, head_i&~tail_i → PACKET.
  - IDLE, ~head_i → error_o[1] set; state unchanged.
  - PACKET, ~head_i&tail_i → IDLE.
  - PACKET, ~head_i&~tail_i → PACKET.
  - PACKET, head_i → error_o[1] set; state unchanged.
- A flit that raises a framing error is still forwarded and still consumes a credit; the transmitter does not drop flits.
- error_o bits clear only on rst.
- packet_active_o = (state == PACKET).

## Timing
- Reset values: credits_o = BUFFER_SIZE, write_o = 0, data_o = 0, state IDLE, packet_active_o = 0, error_o = 0, so ready_o = 1 after reset.
- Reset mid-operation clears all state immediately (asynchronous). Flits and credits in flight are lost; the downstream buffer is reset on the same rst.
- Latency: valid_i&ready_o at edge N → write_o=1 with that flit during cycle N+1.
- Throughput: one flit per cycle while credits last.
- credit_i at edge N → credits_o incremented after edge N; ready_o may rise in cycle N+1, not in cycle N.
- Invariant: the number of write_o pulses not yet returned as credits never exceeds BUFFER_SIZE.
- Invariant: credits_o ≤ BUFFER_SIZE at all times.
- Width rule: counter arithmetic is done in CNT_W bits, with no wrap at either end.

## Test plan
- Reset then burst: valid_i=1 for 10 cycles with no credit_i → exactly 8 write_o pulses; credits_o steps 8→0; ready_o=0 from cycle 8; flits 9–10 held by the source.
- Credit return: with credits_o=0, pulse credit_i once → credits_o=1 next cycle, ready_o=1, one more flit written, credits_o back to 0.
- Simultaneous: credits_o=3, accept and credit_i in the same cycle for 5 cycles → credits_o stays 3; 5 write_o pulses.
- Overflow: credits_o=8 with no accept, pulse credit_i → credits_o stays 8, error_o=2'b01.
- Framing: send head, body, tail → packet_active_o 0→1→1→0, error_o=0. Then send a body flit while IDLE → error_o[1]=1, flit still on data_o with write_o=1.
- Async reset mid-packet: rst asserted between clock edges with credits_o=2 and state PACKET → immediately credits_o=8, write_o=0, packet_active_o=0, error_o=0.
